// File: rtl/rf_ctrl_pkg.sv
// rf_ctrl_pkg: shared definitions for the register-file access sequencer.
// Holds the command opcode encoding, the sequencer state encoding, default
// widths and a small helper that classifies read-only commands.
package rf_ctrl_pkg;

  localparam int DW_DEF = 16;  // data width, matches register file word
  localparam int AW_DEF = 4;   // register address width (16 registers)

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_MOVE = 3'd4,
    OP_SWAP = 3'd5,
    OP_READ = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_WB   = 3'd3,
    S_WB2  = 3'd4,
    S_RESP = 3'd5
  } state_e;

  // The reserved opcode behaves exactly like READ: no write-back.
  function automatic logic is_read_op(input op_e op);
    return (op == OP_READ) || (op == OP_RSVD);
  endfunction

endpackage

// File: rtl/rf_ctrl_alu.sv
// rf_ctrl_alu: combinational result unit for the register-file sequencer.
// Ports:
//   op    in  operation code (op_e)
//   a, b  in  operands (a from address 1, b from address 2)
//   r     out result word, modulo 2^DW
//   carry out carry of ADD / no-borrow of SUB; 0 for all other ops
module rf_ctrl_alu
  import rf_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  op_e           op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] r,
  output logic          carry
);

  logic [DW:0] sum;
  logic [DW:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // Two's-complement subtract: the top bit is 1 when no borrow occurred.
  assign diff = {1'b0, a} + {1'b0, ~b} + {{DW{1'b0}}, 1'b1};

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    r     = a;
    carry = 1'b0;
    case (op)
      OP_ADD:  {carry, r} = sum;
      OP_SUB:  {carry, r} = diff;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_MOVE: r = b;
      OP_SWAP: r = b;
      default: r = a;  // READ and reserved
    endcase
  end

endmodule

// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl: multi-cycle sequencer driving the 16x16 register file.
// Accepts one command over cmd_valid/cmd_ready, reads two operands, computes a
// result, writes it back through the single write port (write address shares
// rf_readReg1) and returns it over rsp_valid/rsp_ready.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake (ready only in IDLE)
//   cmd_op, cmd_rd, cmd_rs     operation, first/destination reg, second reg
//   rsp_valid/rsp_ready        response handshake, held until accepted
//   rsp_data, rsp_carry        result word and ADD/SUB carry
//   rf_readReg1, rf_readReg2   register file addresses (readReg1 also writes)
//   rf_op1, rf_op2             register file combinational read data
//   rf_wrData, rf_RegWrite     register file write data and enable
module rf_access_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_carry,
  output logic [AW-1:0] rf_readReg1,
  output logic [AW-1:0] rf_readReg2,
  input  logic [DW-1:0] rf_op1,
  input  logic [DW-1:0] rf_op2,
  output logic [DW-1:0] rf_wrData,
  output logic          rf_RegWrite
);

  state_e        state_q, state_d;
  op_e           op_q;
  logic [AW-1:0] rd_q, rs_q;
  logic [DW-1:0] a_q, b_q, r_q;
  logic          carry_q;

  logic [DW-1:0] alu_r;
  logic          alu_carry;

  rf_ctrl_alu #(.DW(DW)) u_alu (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .r     (alu_r),
    .carry (alu_carry)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_EXEC) begin
        r_q     <= alu_r;
        carry_q <= alu_carry;
      end
    end
  end

  // NOTE: command fields and operands carry no reset; they are always loaded
  // before any state reads them, so resetting them would only add logic.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && cmd_valid) begin
      op_q <= op_e'(cmd_op);
      rd_q <= cmd_rd;
      rs_q <= cmd_rs;
    end
    if (state_q == S_READ) begin
      a_q <= rf_op1;
      b_q <= rf_op2;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_data    = '0;
    rsp_carry   = 1'b0;
    rf_readReg1 = '0;
    rf_readReg2 = '0;
    rf_wrData   = '0;
    rf_RegWrite = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = S_READ;
      end
      S_READ: begin
        rf_readReg1 = rd_q;
        rf_readReg2 = rs_q;
        state_d     = S_EXEC;
      end
      S_EXEC: begin
        state_d = is_read_op(op_q) ? S_RESP : S_WB;
      end
      S_WB: begin
        rf_readReg1 = rd_q;
        rf_wrData   = r_q;
        // Gated so that a reset landing mid write-back never commits a write.
        rf_RegWrite = !reset;
        state_d     = (op_q == OP_SWAP) ? S_WB2 : S_RESP;
      end
      S_WB2: begin
        // Second half of SWAP: the original first operand goes to rs.
        rf_readReg1 = rs_q;
        rf_wrData   = a_q;
        rf_RegWrite = !reset;
        state_d     = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = r_q;
        rsp_carry = carry_q;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rf_access_ctrl.sv
// tb_rf_access_ctrl: self-checking bench for rf_access_ctrl. Models the team
// register file (standard reset contents), applies a table of directed
// commands, hand-written corner sequences, and random commands checked
// against an arithmetic reference model.
module tb_rf_access_ctrl;

  localparam logic [2:0] ADD  = 3'd0;
  localparam logic [2:0] SUB  = 3'd1;
  localparam logic [2:0] AND_ = 3'd2;
  localparam logic [2:0] OR_  = 3'd3;
  localparam logic [2:0] MOVE = 3'd4;
  localparam logic [2:0] SWAP = 3'd5;
  localparam logic [2:0] READ = 3'd6;
  localparam logic [2:0] RSVD = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [3:0]  cmd_rd = 4'd0;
  logic [3:0]  cmd_rs = 4'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_carry;
  logic [3:0]  rf_readReg1, rf_readReg2;
  logic [15:0] rf_op1, rf_op2, rf_wrData;
  logic        rf_RegWrite;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  rf_access_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_rd      (cmd_rd),
    .cmd_rs      (cmd_rs),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_carry   (rsp_carry),
    .rf_readReg1 (rf_readReg1),
    .rf_readReg2 (rf_readReg2),
    .rf_op1      (rf_op1),
    .rf_op2      (rf_op2),
    .rf_wrData   (rf_wrData),
    .rf_RegWrite (rf_RegWrite)
  );

  // Team register file: combinational read, write on rising edge.
  function automatic logic [15:0] rf_init(input int i);
    case (i)
      1:  return 16'h1F00;
      2:  return 16'h0054;
      3:  return 16'hF70F;
      4:  return 16'hF07F;
      5:  return 16'h0048;
      6:  return 16'h1234;
      7:  return 16'h8001;
      8:  return 16'hAAAA;
      9:  return 16'h5555;
      10: return 16'h0F0F;
      11: return 16'h7FFF;
      12: return 16'hFFFF;
      13: return 16'h0002;
      14: return 16'h8000;
      15: return 16'h0001;
      default: return 16'h0000;
    endcase
  endfunction

  logic [15:0] rf_mem [16];
  logic        rf_load = 1'b1;

  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= rf_init(i);
    end else if (rf_RegWrite) begin
      rf_mem[rf_readReg1] <= rf_wrData;
    end
  end

  assign rf_op1 = rf_mem[rf_readReg1];
  assign rf_op2 = rf_mem[rf_readReg2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected timing from the command class.
  function automatic int exp_lat(input logic [2:0] op);
    if (op == SWAP) return 5;
    if (op == READ || op == RSVD) return 3;
    return 4;
  endfunction

  function automatic logic [7:0] exp_mask(input logic [2:0] op);
    if (op == SWAP) return 8'b0001_1000;
    if (op == READ || op == RSVD) return 8'b0000_0000;
    return 8'b0000_1000;
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1; rf_load = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; rf_load = 1'b0;
  endtask

  // Issue one command, record response latency (cycles after the accept
  // edge), the cycles in which a write was seen, and the response. With
  // hold>0 the response is refused for that many cycles while a stray
  // command is presented; it must be ignored and the response held steady.
  task automatic run_cmd(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs,
                         input int hold, output logic [15:0] data, output logic carry,
                         output int lat, output logic [7:0] wmask);
    int  n;
    logic stable;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs;
    rsp_ready = (hold == 0);
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0; wmask = '0; data = '0; carry = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (rsp_valid) begin
        lat = c;
        break;
      end
      if (rf_RegWrite) wmask[c] = 1'b1;
      @(negedge clk);
    end
    if (lat == 0) begin
      check("rsp_timeout", 32'(rsp_valid), 32'd1);
      reset_dut();
      return;
    end
    data  = rsp_data;
    carry = rsp_carry;
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1; cmd_op = ADD; cmd_rd = rs; cmd_rs = rd;
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== data || rsp_carry !== carry ||
          cmd_ready !== 1'b0 || rf_RegWrite !== 1'b0)
        stable = 1'b0;
    end
    if (hold > 0) check("hold_stable", 32'(stable), 32'd1);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [15:0] exp_data;
    logic        exp_carry;
    logic [15:0] exp_rd;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs,
                              input logic [15:0] d, input logic c, input logic [15:0] r);
    vec_t v;
    v.op = op; v.rd = rd; v.rs = rs; v.exp_data = d; v.exp_carry = c; v.exp_rd = r;
    return v;
  endfunction

  // Reference: result and carry from plain integer arithmetic.
  task automatic ref_exec(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] r, output logic c);
    int t;
    c = 1'b0;
    case (op)
      ADD: begin
        t = int'(a) + int'(b);
        c = (t >= 65536);
        r = 16'(t % 65536);
      end
      SUB: begin
        t = int'(a) - int'(b);
        c = (a >= b);
        if (t < 0) t += 65536;
        r = 16'(t);
      end
      AND_:       r = a & b;
      OR_:        r = a | b;
      MOVE, SWAP: r = b;
      default:    r = a;
    endcase
  endtask

  vec_t        vecs [12];
  logic [15:0] ref_rf [16];
  logic [15:0] d, ra, rb, er;
  logic        cy, ec;
  int          lat, mism;
  logic [7:0]  wm;
  logic [2:0]  rop;
  logic [3:0]  rrd, rrs;

  initial begin
    vecs[0]  = mk(ADD,  4'd1,  4'd2,  16'h1F54, 1'b0, 16'h1F54);
    vecs[1]  = mk(ADD,  4'd12, 4'd13, 16'h0001, 1'b1, 16'h0001);
    vecs[2]  = mk(AND_, 4'd3,  4'd4,  16'hF00F, 1'b0, 16'hF00F);
    vecs[3]  = mk(OR_,  4'd3,  4'd4,  16'hF07F, 1'b0, 16'hF07F);
    vecs[4]  = mk(SWAP, 4'd5,  4'd5,  16'h0048, 1'b0, 16'h0048);
    vecs[5]  = mk(READ, 4'd8,  4'd0,  16'hAAAA, 1'b0, 16'hAAAA);
    vecs[6]  = mk(RSVD, 4'd13, 4'd1,  16'h0002, 1'b0, 16'h0002);
    vecs[7]  = mk(SUB,  4'd2,  4'd2,  16'h0000, 1'b1, 16'h0000);
    vecs[8]  = mk(MOVE, 4'd6,  4'd13, 16'h0002, 1'b0, 16'h0002);
    vecs[9]  = mk(SUB,  4'd14, 4'd15, 16'h7FFF, 1'b1, 16'h7FFF);
    vecs[10] = mk(ADD,  4'd11, 4'd15, 16'h8000, 1'b0, 16'h8000);
    vecs[11] = mk(SUB,  4'd15, 4'd14, 16'h8002, 1'b0, 16'h8002);

    // Reset state.
    reset_dut();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    check("rst_rsp_carry", 32'(rsp_carry), 32'd0);
    check("rst_addr",      32'({rf_readReg1, rf_readReg2}), 32'd0);
    check("rst_wr",        32'({rf_wrData, rf_RegWrite}), 32'd0);

    // Directed table, applied back to back from the standard contents.
    foreach (vecs[i]) begin
      run_cmd(vecs[i].op, vecs[i].rd, vecs[i].rs, 0, d, cy, lat, wm);
      check($sformatf("vec%0d_data", i),  32'(d),   32'(vecs[i].exp_data));
      check($sformatf("vec%0d_carry", i), 32'(cy),  32'(vecs[i].exp_carry));
      check($sformatf("vec%0d_lat", i),   32'(lat), 32'(exp_lat(vecs[i].op)));
      check($sformatf("vec%0d_wmask", i), 32'(wm),  32'(exp_mask(vecs[i].op)));
      check($sformatf("vec%0d_reg", i),   32'(rf_mem[vecs[i].rd]), 32'(vecs[i].exp_rd));
    end

    // SUB with borrow from the standard contents.
    reset_dut();
    run_cmd(SUB, 4'd2, 4'd1, 0, d, cy, lat, wm);
    check("sub_data",  32'(d),  32'h0000_E154);
    check("sub_carry", 32'(cy), 32'd0);
    check("sub_r2",    32'(rf_mem[2]), 32'h0000_E154);

    // SWAP of distinct registers: two consecutive write cycles.
    reset_dut();
    run_cmd(SWAP, 4'd1, 4'd2, 0, d, cy, lat, wm);
    check("swap_data",  32'(d),  32'h0000_0054);
    check("swap_wmask", 32'(wm), 32'h0000_0018);
    check("swap_r1",    32'(rf_mem[1]), 32'h0000_0054);
    check("swap_r2",    32'(rf_mem[2]), 32'h0000_1F00);

    // READ with the response refused for 10 cycles and a stray command.
    run_cmd(READ, 4'd8, 4'd0, 10, d, cy, lat, wm);
    check("hold_data",  32'(d),  32'h0000_AAAA);
    check("hold_wmask", 32'(wm), 32'd0);
    check("hold_r8",    32'(rf_mem[8]), 32'h0000_AAAA);
    check("hold_r1",    32'(rf_mem[1]), 32'h0000_0054);

    // Reset asserted during WB of ADD r1,r2: no write may land.
    reset_dut();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = ADD; cmd_rd = 4'd1; cmd_rs = 4'd2; rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("wb_reached", 32'(rf_RegWrite), 32'd1);
    reset = 1'b1;
    #1;
    check("wb_reset_gate", 32'(rf_RegWrite), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("wbrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("wbrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("wbrst_r1",        32'(rf_mem[1]), 32'h0000_1F00);

    // Random commands against the reference model.
    reset_dut();
    for (int i = 0; i < 16; i++) ref_rf[i] = rf_init(i);
    for (int t = 0; t < 40; t++) begin
      rop = 3'($urandom_range(0, 7));
      rrd = 4'($urandom_range(0, 15));
      rrs = 4'($urandom_range(0, 15));
      ra  = ref_rf[rrd];
      rb  = ref_rf[rrs];
      ref_exec(rop, ra, rb, er, ec);
      run_cmd(rop, rrd, rrs, $urandom_range(0, 3), d, cy, lat, wm);
      if (rop == SWAP) begin
        ref_rf[rrd] = rb;
        ref_rf[rrs] = ra;
      end else if (rop != READ && rop != RSVD) begin
        ref_rf[rrd] = er;
      end
      check($sformatf("rnd%0d_data", t),  32'(d),   32'(er));
      check($sformatf("rnd%0d_carry", t), 32'(cy),  32'(ec));
      check($sformatf("rnd%0d_lat", t),   32'(lat), 32'(exp_lat(rop)));
      mism = 0;
      for (int i = 0; i < 16; i++) if (rf_mem[i] !== ref_rf[i]) mism++;
      check($sformatf("rnd%0d_rf", t), 32'(mism), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
